// File: rtl/lane_rr_merge_if.sv
// rtl/lane_rr_merge_if.sv - valid/ready lane interface carried into and out of lane_rr_merge
//
// Purpose: one valid/ready stream with a WIDTH-bit payload.
// Signals:
//   valid  - producer has a beat on data
//   ready  - consumer takes the beat on this rising edge when valid is high
//   data   - payload, held stable by the producer until accepted
// Modports:
//   src - producer side (drives valid/data, observes ready)
//   snk - consumer side (observes valid/data, drives ready)
interface lane_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport src (output valid, output data, input ready);
  modport snk (input valid, input data, output ready);
endinterface

// File: rtl/lane_rr_merge.sv
// rtl/lane_rr_merge.sv - round-robin merge of NLANES valid/ready lanes into one tagged stream
//
// Purpose: picks one valid input lane per cycle in round-robin order, stores
// {lane tag, payload} in a DEPTH-entry FIFO and presents the oldest entry on
// out_lane together with the tag of the lane it came from.
// Ports:
//   clk           - single clock, all state changes on the rising edge
//   rst           - synchronous active-high reset
//   in_lanes      - NLANES input lanes (snk side); ready driven here
//   out_lane      - merged output stream (src side)
//   out_tag       - source lane index of out_lane.data (0 while out_lane.valid is low)
//   accept_count  - free-running count of accepted input beats, wraps at 16 bits
//   idle          - FIFO empty and no input lane asserting valid
module lane_rr_merge #(
  parameter int NLANES = 2,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int TAGW   = $clog2(NLANES)
) (
  input  logic            clk,
  input  logic            rst,
  lane_if.snk             in_lanes [NLANES-1:0],
  lane_if.src             out_lane,
  output logic [TAGW-1:0] out_tag,
  output logic [15:0]     accept_count,
  output logic            idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Flattened view of the lane interface array so the arbiter can index
  // lanes with a run-time value.
  logic [NLANES-1:0] lane_valid;
  logic [NLANES-1:0] lane_ready;
  logic [WIDTH-1:0]  lane_data [NLANES];

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign lane_valid[i]      = in_lanes[i].valid;
    assign lane_data[i]       = in_lanes[i].data;
    assign in_lanes[i].ready  = lane_ready[i];
  end

  // State
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [TAGW-1:0]  last_grant_q, last_grant_d;
  logic [15:0]      accept_count_q, accept_count_d;
  logic [TAGW-1:0]  mem_tag_q  [DEPTH];
  logic [TAGW-1:0]  mem_tag_d  [DEPTH];
  logic [WIDTH-1:0] mem_data_q [DEPTH];
  logic [WIDTH-1:0] mem_data_d [DEPTH];

  // Arbiter outputs
  logic            gnt_found;
  logic [TAGW-1:0] gnt_idx;
  logic            can_push;
  logic            push;
  logic            pop;
  logic            fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);

  // Space is judged on the registered count only: a pop in the same cycle
  // does not open a slot, so a full FIFO never accepts a beat. Reset also
  // closes the door so no beat looks accepted to the producers.
  assign can_push = (count_q < CW'(DEPTH)) && !rst;

  // Round-robin search starting one past the last accepted lane. The
  // candidate index is reduced with a single conditional subtract since it
  // never exceeds 2*NLANES-1.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NLANES; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NLANES) begin
        cand = cand - NLANES;
      end
      if (!gnt_found && lane_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = TAGW'(cand);
      end
    end
  end

  assign push = can_push && gnt_found;
  assign pop  = fifo_nonempty && out_lane.ready;

  // Only the granted lane sees ready, and only when the beat will be stored.
  always_comb begin
    lane_ready = '0;
    if (push) begin
      lane_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    last_grant_d   = last_grant_q;
    accept_count_d = accept_count_q;
    mem_tag_d      = mem_tag_q;
    mem_data_d     = mem_data_q;

    if (push) begin
      mem_tag_d[wr_ptr_q]  = gnt_idx;
      mem_data_d[wr_ptr_q] = lane_data[gnt_idx];
      wr_ptr_d             = wr_ptr_q + PW'(1);
      last_grant_d         = gnt_idx;
      accept_count_d       = accept_count_q + 16'd1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Registers. Payload storage is not reset; the outputs are masked while
  // the FIFO is empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      last_grant_q   <= TAGW'(NLANES - 1);
      accept_count_q <= '0;
    end else begin
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      last_grant_q   <= last_grant_d;
      accept_count_q <= accept_count_d;
    end
    mem_tag_q  <= mem_tag_d;
    mem_data_q <= mem_data_d;
  end

  // Outputs
  assign out_lane.valid = fifo_nonempty;
  assign out_lane.data  = fifo_nonempty ? mem_data_q[rd_ptr_q] : '0;
  assign out_tag        = fifo_nonempty ? mem_tag_q[rd_ptr_q]  : '0;
  assign accept_count   = accept_count_q;
  assign idle           = !fifo_nonempty && !(|lane_valid);

endmodule

// File: tb/tb_lane_rr_merge.sv
// tb/tb_lane_rr_merge.sv - self-checking bench for lane_rr_merge with a queue-based reference model
module tb_lane_rr_merge;
  localparam int NL    = 2;
  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int TAGW  = 1;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [W-1:0]    data;
  } ent_t;

  logic            clk;
  logic            rst;
  logic            out_ready;
  logic [NL-1:0]   lv;
  logic [NL-1:0]   lr;
  logic [NL-1:0]   auto_en;
  logic [W-1:0]    ld [NL];
  logic [TAGW-1:0] out_tag;
  logic [15:0]     accept_count;
  logic            idle;
  bit              rand_en;

  int errors = 0;
  int checks = 0;

  lane_if #(.WIDTH(W)) lanes [NL-1:0] ();
  lane_if #(.WIDTH(W)) out_if ();

  for (genvar g = 0; g < NL; g++) begin : g_drv
    assign lanes[g].valid = lv[g];
    assign lanes[g].data  = ld[g];
    assign lr[g]          = lanes[g].ready;
  end
  assign out_if.ready = out_ready;

  lane_rr_merge #(.NLANES(NL), .WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_lanes     (lanes),
    .out_lane     (out_if),
    .out_tag      (out_tag),
    .accept_count (accept_count),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {tag,data}, the last granted lane and a
  // beat counter. Checked and advanced once per cycle on the falling edge,
  // when inputs (changed just after the rising edge) are stable.
  ent_t          mq[$];
  int            m_last;
  logic [15:0]   m_acc;
  logic [NL-1:0] acc_mask;
  logic [NL-1:0] exp_ready;
  int            g_sel;
  int            cidx;
  ent_t          e_new;

  always @(negedge clk) begin
    acc_mask = '0;
    if (rst) begin
      mq.delete();
      m_last = NL - 1;
      m_acc  = 16'd0;
    end else begin
      g_sel = -1;
      if (mq.size() < DEPTH) begin
        for (int k = 1; k <= NL; k++) begin
          cidx = (m_last + k) % NL;
          if (g_sel < 0 && lv[cidx]) g_sel = cidx;
        end
      end
      exp_ready = '0;
      if (g_sel >= 0) exp_ready[g_sel] = 1'b1;

      check("lane_ready", 32'(lr), 32'(exp_ready));
      check("out_valid", 32'(out_if.valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("out_data", 32'(out_if.data), 32'(mq[0].data));
        check("out_tag", 32'(out_tag), 32'(mq[0].tag));
      end else begin
        check("out_tag_empty", 32'(out_tag), 32'd0);
      end
      check("accept_count", 32'(accept_count), 32'(m_acc));
      check("idle", 32'(idle), 32'((mq.size() == 0) && (lv == '0)));

      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (g_sel >= 0) begin
        e_new.tag  = TAGW'(g_sel);
        e_new.data = ld[g_sel];
        mq.push_back(e_new);
        m_last = g_sel;
        m_acc  = m_acc + 16'd1;
        acc_mask[g_sel] = 1'b1;
      end
    end
  end

  // Advance one cycle: inputs change just after the rising edge.
  // Accepted auto lanes present their next incrementing payload.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      if (acc_mask[i]) begin
        if (auto_en[i]) ld[i] = ld[i] + 8'd1;
        else lv[i] = 1'b0;
      end
      if (rand_en && !lv[i] && ($urandom_range(3) != 0)) begin
        lv[i] = 1'b1;
        ld[i] = W'($urandom);
      end
    end
    if (rand_en) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic lanes_off();
    lv      = '0;
    auto_en = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    rand_en   = 1'b0;
    lv        = '0;
    auto_en   = '0;
    ld[0]     = '0;
    ld[1]     = '0;

    // Reset state and single beat through an empty FIFO
    tick();
    tick();
    rst = 1'b0;
    at_neg();
    check("rst_out_valid", 32'(out_if.valid), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_data", 32'(out_if.data), 32'd0);
    check("rst_acc", 32'(accept_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    tick();
    lv[0] = 1'b1;
    ld[0] = 8'h11;
    at_neg();
    check("t1_ready", 32'(lr), 32'b01);
    tick();
    at_neg();
    check("t1_valid", 32'(out_if.valid), 32'd1);
    check("t1_data", 32'(out_if.data), 32'h11);
    check("t1_tag", 32'(out_tag), 32'd0);
    check("t1_acc", 32'(accept_count), 32'd1);
    tick();
    at_neg();
    check("t1_idle", 32'(idle), 32'd1);
    tick();

    // Both lanes streaming: tags alternate starting from lane 0
    do_reset();
    out_ready = 1'b1;
    lv = 2'b11; auto_en = 2'b11; ld[0] = 8'hA0; ld[1] = 8'hB0;
    for (int k = 0; k < 9; k++) begin
      at_neg();
      if (k > 0) begin
        check("t2_tag", 32'(out_tag), 32'((k - 1) % 2));
        check("t2_data", 32'(out_if.data),
              32'((((k - 1) % 2) != 0 ? 8'hB0 : 8'hA0) + ((k - 1) / 2)));
      end
      if (k == 8) check("t2_acc", 32'(accept_count), 32'd8);
      tick();
    end
    lanes_off();

    // Backpressure: exactly DEPTH beats, then drain in order
    do_reset();
    out_ready = 1'b0;
    lv = 2'b11; auto_en = 2'b11; ld[0] = 8'hA0; ld[1] = 8'hB0;
    at_neg(); tick();
    at_neg(); tick();
    at_neg();
    check("t3_ready_full", 32'(lr), 32'd0);
    check("t3_head_data", 32'(out_if.data), 32'hA0);
    check("t3_head_tag", 32'(out_tag), 32'd0);
    check("t3_acc", 32'(accept_count), 32'd2);
    tick();
    at_neg();
    check("t3_ready_full2", 32'(lr), 32'd0);
    tick();
    out_ready = 1'b1;
    at_neg();
    check("t3_no_passthru", 32'(lr), 32'd0);
    check("t3_drain0", 32'(out_if.data), 32'hA0);
    tick();
    at_neg();
    check("t3_drain1_data", 32'(out_if.data), 32'hB0);
    check("t3_drain1_tag", 32'(out_tag), 32'd1);
    check("t3_resume_lane0", 32'(lr), 32'b01);
    tick();
    at_neg();
    check("t3_next_data", 32'(out_if.data), 32'hA1);
    check("t3_next_tag", 32'(out_tag), 32'd0);
    tick();
    lanes_off();

    // Only lane 1 for three beats, then lane 0 wins
    do_reset();
    out_ready = 1'b1;
    lv = 2'b10; auto_en = 2'b10; ld[1] = 8'hB0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      tick();
    end
    lv[0] = 1'b1; auto_en[0] = 1'b1; ld[0] = 8'hA0;
    at_neg();
    check("t4_acc", 32'(accept_count), 32'd3);
    check("t4_grant_lane0", 32'(lr), 32'b01);
    tick();
    lanes_off();

    // Reset with two entries queued
    do_reset();
    out_ready = 1'b0;
    lv = 2'b11; auto_en = 2'b11; ld[0] = 8'hA0; ld[1] = 8'hB0;
    at_neg(); tick();
    at_neg(); tick();
    at_neg();
    check("t5_full_valid", 32'(out_if.valid), 32'd1);
    tick();
    rst = 1'b1;
    at_neg();
    tick();
    rst = 1'b0;
    at_neg();
    check("t5_valid_cleared", 32'(out_if.valid), 32'd0);
    check("t5_acc_cleared", 32'(accept_count), 32'd0);
    check("t5_first_grant", 32'(lr), 32'b01);
    tick();
    lanes_off();

    // Randomized traffic with occasional resets
    do_reset();
    rand_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst = ($urandom_range(99) == 0);
    end
    rand_en = 1'b0;
    rst = 1'b0;
    lanes_off();

    // Counter wrap at full throughput
    do_reset();
    out_ready = 1'b1;
    lv = 2'b11; auto_en = 2'b11; ld[0] = 8'h00; ld[1] = 8'h80;
    for (int k = 0; k < 65536; k++) begin
      at_neg();
      if (k == 65535) check("t6_acc_max", 32'(accept_count), 32'hFFFF);
      tick();
    end
    at_neg();
    check("t6_acc_wrap", 32'(accept_count), 32'd0);
    tick();
    lanes_off();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_rr_merge.md
# lane_rr_merge

Round-robin merge stage that consumes an array of `lane_if` valid/ready interfaces and funnels them into one output `lane_if` through a small tagged FIFO. It sits directly upstream of the per-lane interface consumers: a generate-instantiated interface array indexed by genvar feeds this block, and its single merged stream goes to a downstream checker. It exercises interface-array ports, modports and genvar-indexed interface references under real valid/ready traffic.

## Interface
Parameters:
- `NLANES`, 2, number of input lanes; legal range 2..8.
- `WIDTH`, 8, payload width in bits.
- `DEPTH`, 2, output FIFO entries; power of two, at least 2.
- `TAGW`, `$clog2(NLANES)`, derived lane-tag width; not overridden.

Interface `lane_if #(WIDTH)`:
- Signals: `valid`, `ready`, `data[WIDTH-1:0]`.
- Modport `src`: valid and data out, ready in.
- Modport `snk`: valid and data in, ready out.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_lanes`  `lane_if.snk`  array [NLANES-1:0]  input lanes; per-lane `ready` is driven by this block.
- `out_lane`  `lane_if.src`  1  merged output stream.
- `out_tag`  output  TAGW  index of the source lane of the current `out_lane.data`.
- `accept_count`  output  16  total input beats accepted; wraps.
- `idle`  output  1  high when the FIFO is empty and no input lane is valid.

## Operation
- FIFO entries are {tag, data}. State is `count` (0..DEPTH), `wr_ptr`, `rd_ptr` and `last_grant`.
- Arbiter is combinational:
  - Only when `count < DEPTH` (registered count; no pass-through when full), grant exactly one valid lane.
  - Search order starts at `last_grant+1` modulo NLANES and proceeds upward with wrap.
  - Only the granted lane sees `ready=1`. All other `in_lanes[i].ready` are 0.
- Push: when the granted lane has `valid`, write {i, data} at `wr_ptr`, then:
  - `wr_ptr++`
  - `last_grant <= i`
  - `accept_count++` (wraps 65535 -> 0)
- Pop: `out_lane.valid = (count != 0)`, `out_lane.data` and `out_tag` come from the `rd_ptr` entry. When `out_lane.valid && out_lane.ready`, `rd_ptr++`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- A full FIFO blocks push even when a pop happens in the same cycle.
- `last_grant` changes only on an accepted beat. An idle cycle does not rotate priority.
- Input lanes hold `valid` and `data` stable until accepted. This block does not check that rule.
- `idle = (count==0) && !(|valid)`.

## Timing
- Reset values: `count=0`, `wr_ptr=rd_ptr=0`, `last_grant=NLANES-1` (lane 0 has first priority), `accept_count=0`.
  - Consequent outputs: `out_lane.valid=0`, `out_tag=0`, and `idle=1` if no lane is valid.
  - `out_lane.data` is don't-care while `valid=0`; implementation drives 0 after reset.
- Reset mid-operation discards all FIFO contents. `out_lane.valid` is 0 in the cycle after the reset edge. Lane `ready` values during reset cycles are don't-care, but no beat is counted.
- Latency: a beat accepted at edge N is presented on `out_lane` in cycle N+1 if the FIFO was empty.
- Throughput: 1 beat/cycle sustained with `out_lane.ready` held high.
- Backpressure: with `out_lane.ready=0`, exactly DEPTH beats are accepted, then all lane `ready` signals go 0 until a pop frees an entry. The first push after that follows the pop edge by one cycle.
- FIFO pointers wrap modulo DEPTH, and `count` never exceeds DEPTH.

## Test plan
- Reset, then lane0 sends data 0x11 with `out.ready=1` -> `out.valid` rises the next cycle with data 0x11, `out_tag=0`, `accept_count=1`, and `idle` returns to 1 after the pop.
- NLANES=2, both lanes continuously valid (lane0 0xA0.., lane1 0xB0..), `out.ready=1` for 8 cycles -> tags alternate 0,1,0,1,..., 8 beats delivered in order, `accept_count=8`.
- `out.ready=0`, both lanes valid -> exactly 2 beats accepted, then all `ready` signals are 0 and the FIFO holds {0,A0},{1,B0}. Raise `out.ready` -> beats drain in that order and acceptance resumes with lane0.
- Only lane1 valid for 3 beats, then both valid -> lane0 is granted next, because `last_grant=1`.
- Assert `rst` with 2 entries queued -> `out.valid=0` the next cycle, `accept_count=0`, and the first post-reset grant goes to lane0.
- Force 65536 accepted beats -> `accept_count` wraps to 0 with no data loss.
